// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame accumulator: FSM state encoding and
// default bus widths.
package crc_pkg;

    localparam int CRC_SIZE_DEF   = 8;
    localparam int FRAME_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/crc_parallel.sv
// Combinational CRC update over one FRAME_SIZE-bit beat, MSB first, for a
// CRC whose active width is given by a contiguous low-order mask.
module crc_parallel #(
    parameter int CRC_SIZE   = 8,
    parameter int FRAME_SIZE = 8
) (
    input  logic [FRAME_SIZE-1:0] data_i,
    input  logic [CRC_SIZE-1:0]   crc_i,
    input  logic [CRC_SIZE-1:0]   poly_i,
    input  logic [CRC_SIZE-1:0]   size_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [CRC_SIZE-1:0] top_bit;
    logic [CRC_SIZE-1:0] c;
    logic                fb;

    always_comb begin
        // Highest set bit of the mask marks the CRC's MSB position.
        top_bit = size_i ^ (size_i >> 1);
        c       = crc_i & size_i;
        fb      = 1'b0;
        for (int i = FRAME_SIZE - 1; i >= 0; i--) begin
            fb = data_i[i] ^ (|(c & top_bit));
            c  = ((c << 1) & size_i) ^ ({CRC_SIZE{fb}} & poly_i & size_i);
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc_frame_accumulator.sv
// Frame-level CRC accumulator: seeds on start, folds one beat per accepted
// transfer and publishes the final CRC with a one-cycle crc_ready pulse.
module crc_frame_accumulator
    import crc_pkg::*;
#(
    parameter int CRC_SIZE   = CRC_SIZE_DEF,
    parameter int FRAME_SIZE = FRAME_SIZE_DEF,
    parameter int CNT_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CRC_SIZE-1:0]   crc_poly,
    input  logic [CRC_SIZE-1:0]   crc_poly_size,
    input  logic                  crc_poly_wr,
    input  logic [CRC_SIZE-1:0]   crc_init,
    input  logic                  start,
    input  logic                  abort,
    input  logic [FRAME_SIZE-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  data_last,
    output logic                  data_ready,
    output logic                  busy,
    output logic [CRC_SIZE-1:0]   crc_out,
    output logic                  crc_ready,
    output logic [CNT_SIZE-1:0]   beat_count
);

    state_e              state_q, state_d;
    logic [CRC_SIZE-1:0] crc_q, crc_d;
    logic [CRC_SIZE-1:0] crc_out_q, crc_out_d;
    logic [CRC_SIZE-1:0] poly_q, poly_d;
    logic [CRC_SIZE-1:0] size_q, size_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [CRC_SIZE-1:0] crc_next;
    logic                xfer;

    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
        return (&v) ? v : v + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    endfunction

    crc_parallel #(
        .CRC_SIZE   (CRC_SIZE),
        .FRAME_SIZE (FRAME_SIZE)
    ) u_crc_parallel (
        .data_i (data_in),
        .crc_i  (crc_q),
        .poly_i (poly_q),
        .size_i (size_q),
        .crc_o  (crc_next)
    );

    // Abort wins over a transfer presented in the same cycle.
    assign xfer = (state_q == ST_RUN) && data_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            crc_q     <= '0;
            crc_out_q <= '0;
            poly_q    <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            poly_q    <= poly_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                  state_d = ST_IDLE;
                else if (xfer && data_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        poly_d    = poly_q;
        size_d    = size_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        cnt_d     = cnt_q;
        if (state_q == ST_IDLE) begin
            if (crc_poly_wr) begin
                poly_d = crc_poly;
                size_d = crc_poly_size;
            end
            if (start) begin
                crc_d = crc_init;
                cnt_d = '0;
            end
        end
        if (xfer) begin
            crc_d = crc_next;
            cnt_d = sat_inc(cnt_q);
            if (data_last) crc_out_d = crc_next;
        end
    end

    always_comb begin
        busy       = (state_q == ST_RUN);
        data_ready = (state_q == ST_RUN);
        crc_ready  = (state_q == ST_DONE);
    end

    assign crc_out    = crc_out_q;
    assign beat_count = cnt_q;

endmodule

// File: doc/crc_frame_accumulator.md
CRC_FRAME_ACCUMULATOR -- requirements
Module: crc_frame_accumulator

Interface
REQ-001 Parameter CRC_SIZE, default 8: maximum CRC width in bits; width of poly, size, init and result buses.
REQ-002 Parameter FRAME_SIZE, default 8: data beat width in bits, consumed one beat per accepted transfer.
REQ-003 Parameter CNT_SIZE, default 16: width of beat counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 crc_poly  input  CRC_SIZE  polynomial without implicit MSB, sampled on crc_poly_wr.
REQ-007 crc_poly_size  input  CRC_SIZE  active-width mask for crc_parallel, sampled on crc_poly_wr.
REQ-008 crc_poly_wr  input  1  polynomial/size register write strobe.
REQ-009 crc_init  input  CRC_SIZE  seed value, sampled on start.
REQ-010 start  input  1  single-cycle frame start request.
REQ-011 abort  input  1  discard current frame.
REQ-012 data_in  input  FRAME_SIZE  data beat, MSB first.
REQ-013 data_valid  input  1  data_in valid this cycle.
REQ-014 data_last  input  1  qualifies final beat of frame.
REQ-015 data_ready  output  1  block accepts a beat this cycle.
REQ-016 busy  output  1  frame in progress (state RUN).
REQ-017 crc_out  output  CRC_SIZE  registered frame CRC.
REQ-018 crc_ready  output  1  one-cycle pulse, crc_out valid.
REQ-019 beat_count  output  CNT_SIZE  beats accepted in current/last frame.

Function
REQ-020 FSM SHALL have states IDLE, RUN, DONE; data_ready = busy = (state==RUN).
REQ-021 IDLE: crc_poly_wr SHALL load poly/size registers; crc_poly_wr in RUN or DONE SHALL be ignored.
REQ-022 IDLE and start=1: crc register <= crc_init, beat_count <= 0, next state RUN; same-cycle crc_poly_wr SHALL take effect (poly write before frame use).
REQ-023 RUN: transfer occurs when data_valid & data_ready; crc register <= crc_parallel(data_in, crc register, poly, size); beat_count += 1, saturating at all-ones.
REQ-024 RUN, transfer with data_last=1: next state DONE; crc_out <= updated CRC in same edge.
REQ-025 DONE: crc_ready=1 for exactly one cycle, then IDLE; latency last-beat edge to crc_ready high = 1 cycle.
REQ-026 crc_out and beat_count SHALL hold until next start.
REQ-027 data_last without data_valid SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-028 abort in RUN (priority over same-cycle transfer) SHALL return to IDLE, no crc_ready, crc_out unchanged; abort in IDLE/DONE no effect.
REQ-029 Zero-beat frame impossible; frame ends only on an accepted last beat.
REQ-030 Back-to-back beats SHALL be accepted every cycle with no bubbles.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, crc register/crc_out/beat_count/poly/size to 0, crc_ready/data_ready/busy to 0.
REQ-032 Reset mid-frame SHALL discard the frame; poly must be rewritten afterwards.

Structure
REQ-033 State encoding constants SHALL live in shared package crc_pkg (header), alongside default CRC_SIZE/FRAME_SIZE.
REQ-034 Exactly one sub-module: existing crc_parallel instance (CRC_SIZE, FRAME_SIZE) computing the combinational next CRC; no other datapath logic duplicated.

Verification (CRC_SIZE=8, FRAME_SIZE=8, poly 0x07, full-width size, init 0x00 unless stated)
REQ-035 Beats "123456789" (0x31..0x39), last on 0x39 -> crc_out=0xF4, crc_ready one cycle after last, beat_count=9.
REQ-036 Single beat 0x01 with last -> crc_out=0x07, beat_count=1; single beat 0x00 -> 0x00.
REQ-037 Same 9 beats with data_valid toggled every other cycle -> crc_out=0xF4, count=9.
REQ-038 Abort after 4 beats, then fresh frame 0x01 -> no crc_ready for aborted frame, second gives 0x07.
REQ-039 crc_poly_wr 0x31 during RUN -> ignored, 0x01 frame still yields 0x07; rst_n low mid-frame -> all outputs 0, state IDLE.
REQ-040 CRC_SIZE=16, poly 0x1021, init 0x0000, "123456789" -> crc_out=0x31C3.
